// File: rtl/mc_controller_hs.sv
// mc_controller_hs: multicycle MIPS-subset control FSM with a stallable memory handshake
module mc_controller_hs #(
   parameter int MEM_HANDSHAKE = 1,
   parameter int HAS_BNE       = 1,
   parameter int HAS_IMM_LOGIC = 1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [5:0] op,
   input  logic [5:0] funct,
   input  logic       zero,
   input  logic       mem_ready,
   output logic       mem_req,
   output logic       irwrite,
   output logic       memwrite,
   output logic       iord,
   output logic       pcen,
   output logic [1:0] pcsrc,
   output logic [2:0] alucontrol,
   output logic [1:0] alusrcb,
   output logic       alusrca,
   output logic       regwrite,
   output logic       regdst,
   output logic       memtoreg,
   output logic       bne_sign,
   output logic       zeroext,
   output logic       illegal
);
   typedef enum logic [3:0] {
      FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, REX, RWB, BREX, IEX, IWB, JEX
   } state_t;
   state_t state, next;
   logic done, is_lw, is_sw, is_r, is_br, is_bne, is_addi, is_andi, is_ori, is_j, r_ok, imm_logic;
   logic [2:0] r_alu, i_alu;
   assign done      = mem_ready | (MEM_HANDSHAKE == 0);
   assign is_lw     = op == 6'b100011;
   assign is_sw     = op == 6'b101011;
   assign is_r      = op == 6'b000000;
   assign is_bne    = op == 6'b000101;
   assign is_br     = op == 6'b000100 | (is_bne & (HAS_BNE != 0));
   assign is_addi   = op == 6'b001000;
   assign is_andi   = op == 6'b001100 & (HAS_IMM_LOGIC != 0);
   assign is_ori    = op == 6'b001101 & (HAS_IMM_LOGIC != 0);
   assign is_j      = op == 6'b000010;
   assign imm_logic = is_andi | is_ori;
   assign r_ok      = funct == 6'b100000 | funct == 6'b100010 | funct == 6'b100100 |
                      funct == 6'b100101 | funct == 6'b101010;
   assign r_alu     = funct == 6'b100010 ? 3'b110 : funct == 6'b100100 ? 3'b000 :
                      funct == 6'b100101 ? 3'b001 : funct == 6'b101010 ? 3'b111 : 3'b010;
   assign i_alu     = is_andi ? 3'b000 : is_ori ? 3'b001 : 3'b010;
   always_ff @(posedge clk or posedge reset)
      if (reset) state <= FETCH;
      else state <= next;
   always_comb begin
      next = state;
      mem_req = 1'b0;
      irwrite = 1'b0;
      memwrite = 1'b0;
      iord = 1'b0;
      pcen = 1'b0;
      pcsrc = 2'b00;
      alucontrol = 3'b000;
      alusrcb = 2'b00;
      alusrca = 1'b0;
      regwrite = 1'b0;
      regdst = 1'b0;
      memtoreg = 1'b0;
      bne_sign = 1'b0;
      zeroext = 1'b0;
      illegal = 1'b0;
      case (state)
         FETCH: begin
            mem_req = 1'b1;
            alusrcb = 2'b01;
            alucontrol = 3'b010;
            irwrite = done;
            pcen = done;
            next = done ? DECODE : FETCH;
         end
         DECODE: begin
            alusrcb = 2'b11;
            alucontrol = 3'b010;
            next = (is_lw | is_sw) ? MEMADR : (is_r & r_ok) ? REX : is_br ? BREX :
                   (is_addi | imm_logic) ? IEX : is_j ? JEX : FETCH;
            illegal = !(is_lw | is_sw | (is_r & r_ok) | is_br | is_addi | imm_logic | is_j);
         end
         MEMADR: begin
            alusrca = 1'b1;
            alusrcb = 2'b10;
            alucontrol = 3'b010;
            next = is_sw ? MEMWR : MEMRD;
         end
         MEMRD: begin
            mem_req = 1'b1;
            iord = 1'b1;
            next = done ? MEMWB : MEMRD;
         end
         MEMWB: begin
            regwrite = 1'b1;
            memtoreg = 1'b1;
            next = FETCH;
         end
         MEMWR: begin
            mem_req = 1'b1;
            iord = 1'b1;
            memwrite = 1'b1;
            next = done ? FETCH : MEMWR;
         end
         REX: begin
            alusrca = 1'b1;
            alucontrol = r_alu;
            next = RWB;
         end
         RWB: begin
            regwrite = 1'b1;
            regdst = 1'b1;
            alucontrol = r_alu;
            next = FETCH;
         end
         BREX: begin
            alusrca = 1'b1;
            alucontrol = 3'b110;
            pcsrc = 2'b01;
            bne_sign = is_bne;
            pcen = zero ^ is_bne;
            next = FETCH;
         end
         IEX: begin
            alusrca = 1'b1;
            alusrcb = 2'b10;
            alucontrol = i_alu;
            zeroext = imm_logic;
            next = IWB;
         end
         IWB: begin
            regwrite = 1'b1;
            alucontrol = i_alu;
            zeroext = imm_logic;
            next = FETCH;
         end
         JEX: begin
            pcsrc = 2'b10;
            pcen = 1'b1;
            next = FETCH;
         end
         default: next = FETCH;
      endcase
      // state is already FETCH under reset; only the side-effecting enables need masking
      if (reset) begin
         mem_req = 1'b0;
         irwrite = 1'b0;
         memwrite = 1'b0;
         pcen = 1'b0;
         regwrite = 1'b0;
      end
   end
endmodule

// File: tb/tb_mc_controller_hs.sv
// tb_mc_controller_hs: randomized scoreboard bench; instance 0 uses default parameters,
// instance 1 has no handshake, no bne and no andi/ori
module tb_mc_controller_hs;
   typedef struct packed {
      logic mem_req, irwrite, memwrite, iord, pcen;
      logic [1:0] pcsrc;
      logic [2:0] aluc;
      logic [1:0] srcb;
      logic srca, regwrite, regdst, memtoreg, bne_sign, zeroext, illegal;
   } out_t;
   typedef struct {
      out_t e;
      out_t m;
      string nm;
   } exp_t;
   typedef enum {K_LW, K_SW, K_R, K_BR, K_I, K_J, K_ILL} kind_t;
   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic       reset [2];
   logic [5:0] op [2];
   logic [5:0] funct [2];
   logic       zero [2];
   logic       mem_ready [2];
   out_t       act [2];
   exp_t q0[$], q1[$];
   int tests = 0, fails = 0;
   genvar g;
   generate
      for (g = 0; g < 2; g++) begin : u
         logic mem_req, irwrite, memwrite, iord, pcen, alusrca, regwrite, regdst, memtoreg;
         logic bne_sign, zeroext, illegal;
         logic [1:0] pcsrc, alusrcb;
         logic [2:0] alucontrol;
         mc_controller_hs #(
            .MEM_HANDSHAKE(g == 0 ? 1 : 0),
            .HAS_BNE(g == 0 ? 1 : 0),
            .HAS_IMM_LOGIC(g == 0 ? 1 : 0)
         ) dut (
            .clk(clk), .reset(reset[g]), .op(op[g]), .funct(funct[g]), .zero(zero[g]),
            .mem_ready(mem_ready[g]), .mem_req(mem_req), .irwrite(irwrite), .memwrite(memwrite),
            .iord(iord), .pcen(pcen), .pcsrc(pcsrc), .alucontrol(alucontrol), .alusrcb(alusrcb),
            .alusrca(alusrca), .regwrite(regwrite), .regdst(regdst), .memtoreg(memtoreg),
            .bne_sign(bne_sign), .zeroext(zeroext), .illegal(illegal)
         );
         assign act[g] = {mem_req, irwrite, memwrite, iord, pcen, pcsrc, alucontrol, alusrcb,
                          alusrca, regwrite, regdst, memtoreg, bne_sign, zeroext, illegal};
      end
   endgenerate
   task automatic chk(int k, out_t a, exp_t x);
      tests++;
      if (((a ^ x.e) & x.m) != '0) begin
         fails++;
         $display("FAIL inst%0d %s: got %b required %b (mask %b) t=%0t", k, x.nm, a, x.e, x.m, $time);
      end
   endtask
   always @(negedge clk) begin
      if (q0.size() > 0) chk(0, act[0], q0.pop_front());
      if (q1.size() > 0) chk(1, act[1], q1.pop_front());
   end
   function automatic kind_t kind(int k, logic [5:0] o, logic [5:0] f);
      bit r_ok;
      r_ok = f == 6'h20 || f == 6'h22 || f == 6'h24 || f == 6'h25 || f == 6'h2a;
      case (o)
         6'h23: return K_LW;
         6'h2b: return K_SW;
         6'h00: return r_ok ? K_R : K_ILL;
         6'h04: return K_BR;
         6'h05: return k == 0 ? K_BR : K_ILL;
         6'h08: return K_I;
         6'h0c, 6'h0d: return k == 0 ? K_I : K_ILL;
         6'h02: return K_J;
         default: return K_ILL;
      endcase
   endfunction
   function automatic logic [2:0] ralu(logic [5:0] f);
      case (f)
         6'h22: return 3'b110;
         6'h24: return 3'b000;
         6'h25: return 3'b001;
         6'h2a: return 3'b111;
         default: return 3'b010;
      endcase
   endfunction
   task automatic cyc(int k, logic r, out_t e, out_t m, string nm);
      exp_t x;
      x.e = e;
      x.m = m;
      x.nm = nm;
      mem_ready[k] = r;
      if (k == 0) q0.push_back(x);
      else q1.push_back(x);
      @(posedge clk);
      #1;
   endtask
   // a memory access: stalls only exist with the handshake; without it mem_ready is held low
   task automatic mem_phase(int k, out_t b, int st, bit isf, string nm);
      out_t d;
      d = b;
      if (isf) begin
         d.irwrite = 1'b1;
         d.pcen = 1'b1;
      end
      if (k == 0) begin
         repeat (st) cyc(k, 1'b0, b, '1, {nm, "_stall"});
         cyc(k, 1'b1, d, '1, nm);
      end else cyc(k, 1'b0, d, '1, nm);
   endtask
   task automatic run(int k, logic [5:0] o, logic [5:0] f, logic z, int fs, int ms);
      out_t x;
      kind_t kd;
      logic [2:0] a;
      kd = kind(k, o, f);
      op[k] = o;
      funct[k] = f;
      zero[k] = z;
      x = '0; x.mem_req = 1; x.srcb = 2'b01; x.aluc = 3'b010;
      mem_phase(k, x, fs, 1, "fetch");
      x = '0; x.srcb = 2'b11; x.aluc = 3'b010; x.illegal = kd == K_ILL;
      cyc(k, 1'($urandom), x, '1, "decode");
      case (kd)
         K_LW, K_SW: begin
            x = '0; x.srca = 1; x.srcb = 2'b10; x.aluc = 3'b010;
            cyc(k, 1'($urandom), x, '1, "memadr");
            x = '0; x.mem_req = 1; x.iord = 1; x.memwrite = kd == K_SW;
            mem_phase(k, x, ms, 0, kd == K_SW ? "memwr" : "memrd");
            if (kd == K_LW) begin
               x = '0; x.regwrite = 1; x.memtoreg = 1;
               cyc(k, 1'($urandom), x, '1, "memwb");
            end
         end
         K_R: begin
            a = ralu(f);
            x = '0; x.srca = 1; x.aluc = a;
            cyc(k, 1'($urandom), x, '1, "rex");
            x = '0; x.regwrite = 1; x.regdst = 1; x.aluc = a;
            cyc(k, 1'($urandom), x, '1, "rwb");
         end
         K_BR: begin
            x = '0; x.srca = 1; x.aluc = 3'b110; x.pcsrc = 2'b01;
            x.bne_sign = o == 6'h05; x.pcen = z ^ (o == 6'h05);
            cyc(k, 1'($urandom), x, '1, "brex");
         end
         K_I: begin
            a = o == 6'h0c ? 3'b000 : o == 6'h0d ? 3'b001 : 3'b010;
            x = '0; x.srca = 1; x.srcb = 2'b10; x.aluc = a; x.zeroext = o != 6'h08;
            cyc(k, 1'($urandom), x, '1, "iex");
            x = '0; x.regwrite = 1; x.aluc = a; x.zeroext = o != 6'h08;
            cyc(k, 1'($urandom), x, '1, "iwb");
         end
         K_J: begin
            x = '0; x.pcsrc = 2'b10; x.pcen = 1;
            cyc(k, 1'($urandom), x, '1, "jex");
         end
         default: ;
      endcase
   endtask
   task automatic stream(int k);
      out_t x, me, mr;
      logic [5:0] ops [10];
      logic [5:0] fs [5];
      logic [5:0] o, f;
      ops = '{6'h23, 6'h2b, 6'h00, 6'h04, 6'h05, 6'h08, 6'h0c, 6'h0d, 6'h02, 6'h3f};
      fs = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2a};
      me = '0; me.mem_req = 1; me.irwrite = 1; me.memwrite = 1; me.pcen = 1; me.regwrite = 1;
      mr = me; mr.iord = 1;
      cyc(k, 1'b1, '0, me, "reset_hold");
      cyc(k, 1'b1, '0, me, "reset_hold");
      reset[k] = 1'b0;
      if (k == 0) begin
         run(0, 6'h00, 6'h20, 0, 0, 0);
         run(0, 6'h23, 6'h00, 0, 3, 2);
         run(0, 6'h04, 6'h00, 1, 0, 0);
         run(0, 6'h05, 6'h00, 1, 1, 0);
         run(0, 6'h0d, 6'h00, 0, 0, 0);
         run(0, 6'h3f, 6'h00, 0, 0, 0);
         run(0, 6'h00, 6'h3f, 0, 0, 0);
         op[0] = 6'h23;
         x = '0; x.mem_req = 1; x.srcb = 2'b01; x.aluc = 3'b010;
         mem_phase(0, x, 0, 1, "fetch");
         x = '0; x.srcb = 2'b11; x.aluc = 3'b010;
         cyc(0, 1'b0, x, '1, "decode");
         x = '0; x.srca = 1; x.srcb = 2'b10; x.aluc = 3'b010;
         cyc(0, 1'b0, x, '1, "memadr");
         x = '0; x.mem_req = 1; x.iord = 1;
         cyc(0, 1'b0, x, '1, "memrd_stall");
         cyc(0, 1'b0, x, '1, "memrd_stall");
         reset[0] = 1'b1;
         cyc(0, 1'b0, '0, mr, "reset_midrd");
         cyc(0, 1'b1, '0, mr, "reset_midrd");
         reset[0] = 1'b0;
      end else begin
         run(1, 6'h05, 6'h00, 1, 0, 0);
         run(1, 6'h2b, 6'h00, 0, 0, 0);
         run(1, 6'h0c, 6'h00, 0, 0, 0);
         run(1, 6'h08, 6'h00, 0, 0, 0);
      end
      for (int i = 0; i < 150; i++) begin
         o = ops[$urandom_range(0, 9)];
         if (o == 6'h3f) o = 6'($urandom);
         f = $urandom_range(0, 4) == 0 ? 6'($urandom) : fs[$urandom_range(0, 4)];
         run(k, o, f, 1'($urandom), $urandom_range(0, 3), $urandom_range(0, 3));
      end
   endtask
   initial begin
      #2_000_000;
      $display("FAIL watchdog: bench did not complete");
      $fatal(1, "timeout");
   end
   initial begin
      for (int i = 0; i < 2; i++) begin
         reset[i] = 1'b1;
         op[i] = '0;
         funct[i] = '0;
         zero[i] = 1'b0;
         mem_ready[i] = 1'b0;
      end
      @(posedge clk);
      #1;
      fork
         stream(0);
         stream(1);
      join
      @(negedge clk);
      #1;
      if (q0.size() + q1.size() != 0) begin
         tests++;
         fails++;
         $display("FAIL drain: %0d expectations left, required 0", q0.size() + q1.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/mc_controller_hs.md
MC_CONTROLLER_HS -- requirements
Module: mc_controller_hs

Interface
REQ-001 SHALL have parameter MEM_HANDSHAKE, default 1: 1 = memory states wait for mem_ready; 0 = mem_ready ignored, one-cycle memory.
REQ-002 SHALL have parameter HAS_BNE, default 1: 1 = bne decoded; 0 = bne is illegal.
REQ-003 SHALL have parameter HAS_IMM_LOGIC, default 1: 1 = andi/ori decoded; 0 = andi/ori are illegal.
REQ-004 SHALL have ports, one per line:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high.
- op  in  6  instr[31:26].
- funct  in  6  instr[5:0].
- zero  in  1  ALU zero flag.
- mem_ready  in  1  memory access completes this cycle.
- mem_req  out  1  memory access requested.
- irwrite  out  1  instruction register load.
- memwrite  out  1  memory write strobe.
- iord  out  1  0 = address from PC, 1 = from ALUOut.
- pcen  out  1  PC load.
- pcsrc  out  2  00 ALU result, 01 ALUOut, 10 jump target.
- alucontrol  out  3  010 add, 110 sub, 000 and, 001 or, 111 slt.
- alusrcb  out  2  00 B, 01 constant 4, 10 imm, 11 imm<<2.
- alusrca  out  1  0 = PC, 1 = register A.
- regwrite  out  1  register file write.
- regdst  out  1  1 = rd, 0 = rt.
- memtoreg  out  1  1 = write data from memory.
- bne_sign  out  1  inverts branch condition.
- zeroext  out  1  immediate zero-extended (andi/ori).
- illegal  out  1  one-cycle pulse on undecoded instruction.

Function
REQ-005 SHALL implement states FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, REX, RWB, BREX, IEX, IWB, JEX.
REQ-006 SHALL drive all outputs not listed for a state to 0.
REQ-007 FETCH: mem_req=1, iord=0, alusrca=0, alusrcb=01, alucontrol=010, pcsrc=00. When done (mem_ready=1, or MEM_HANDSHAKE=0): irwrite=1, pcen=1, go to DECODE. Otherwise hold FETCH with irwrite=pcen=0.
REQ-008 DECODE: alusrca=0, alusrcb=11, alucontrol=010. Next state by op:
- lw 100011 or sw 101011 -> MEMADR.
- R 000000 -> REX.
- beq 000100 or bne 000101 -> BREX.
- addi 001000, andi 001100, ori 001101 -> IEX.
- j 000010 -> JEX.
- anything else -> FETCH with illegal=1.
REQ-009 An R-type funct other than 100000/100010/100100/100101/101010 SHALL be illegal, decided in DECODE.
REQ-010 MEMADR: alusrca=1, alusrcb=10, alucontrol=010. lw -> MEMRD; sw -> MEMWR.
REQ-011 MEMRD: mem_req=1, iord=1. Wait for done as in REQ-007, then -> MEMWB.
REQ-012 MEMWB: regwrite=1, memtoreg=1, regdst=0 -> FETCH.
REQ-013 MEMWR: mem_req=1, iord=1, memwrite=1 held until done, then -> FETCH.
REQ-014 REX: alusrca=1, alusrcb=00, alucontrol from funct (add 010, sub 110, and 000, or 001, slt 111) -> RWB.
REQ-015 RWB: regwrite=1, regdst=1, alucontrol held -> FETCH.
REQ-016 BREX: alusrca=1, alusrcb=00, alucontrol=110, pcsrc=01, bne_sign=(op==000101), pcen=zero^bne_sign -> FETCH.
REQ-017 IEX: alusrca=1, alusrcb=10. alucontrol: addi 010, andi 000, ori 001. zeroext=1 for andi/ori. -> IWB.
REQ-018 IWB: regwrite=1, regdst=0, alucontrol and zeroext held -> FETCH.
REQ-019 JEX: pcsrc=10, pcen=1 -> FETCH.
REQ-020 Instruction-dependent outputs SHALL decode from op/funct, which the datapath holds stable after FETCH.
REQ-021 mem_ready SHALL be ignored outside FETCH, MEMRD and MEMWR.
REQ-022 Stall length SHALL be unbounded; no timeout.

Reset
REQ-023 reset SHALL asynchronously force state FETCH.
REQ-024 While reset=1, mem_req, irwrite, memwrite, pcen and regwrite SHALL be 0.
REQ-025 On first clk edge after reset deasserts, controller SHALL be in FETCH; reset mid-stall SHALL abandon the access.

Verification
REQ-026 add, mem_ready=1 -> 4 cycles FETCH,DECODE,REX,RWB; RWB regwrite=1, regdst=1, alucontrol=010.
REQ-027 lw, mem_ready low 3 cycles in FETCH and 2 cycles in MEMRD -> irwrite/pcen only on the ready cycle; total 10 cycles.
REQ-028 beq zero=1 -> BREX pcen=1; bne zero=1 -> pcen=0, bne_sign=1; HAS_BNE=0 with bne -> illegal=1, return to FETCH.
REQ-029 ori, HAS_IMM_LOGIC=1 -> IEX alucontrol=001, zeroext=1; op=111111 -> illegal pulse, next state FETCH.
REQ-030 MEM_HANDSHAKE=0, sw, mem_ready=0 -> 4 cycles, memwrite=1 for 1 cycle; reset mid-MEMRD -> FETCH, enables 0.
